// File: rtl/data_ram.sv
// data_ram: single-port data memory with byte strobes, valid/ready request
// port, error responses, optional output register and post-reset clear.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req_valid/ready request handshake; ready depends on FSM state only
//   req_we          1 = write, 0 = read
//   req_addr        byte address; misaligned or out-of-range -> error
//   req_wdata       write data
//   req_be          byte enables, bit i covers bits 8i+7:8i
//   rsp_valid       one-cycle response pulse per accepted request
//   rsp_rdata       read data, zero for writes, errors and idle cycles
//   rsp_err         error flag qualified by rsp_valid
//   busy            clear sequencer running
module data_ram #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          OUT_REG        = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned B  = $clog2(NB);
    localparam int unsigned I  = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LO_MASK =
        ADDR_W'((64'd1 << B) - 64'd1);
    localparam logic [I-1:0] LAST = I'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    state_e          state_q;
    logic [I-1:0]    cnt_q;
    logic            busy_q;
    logic            ready_q;

    logic            mis;
    logic            oor;
    logic            err;
    logic            accept;
    logic [I-1:0]    widx;
    logic            mem_we;
    logic            mem_rd;
    logic            clr_we;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    logic              v1_q, v1_d;
    logic              e1_q, e1_d;
    logic              r1_q, r1_d;
    logic [DATA_W-1:0] s1_data;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    // Low bits select a byte inside a word and must be zero; any bit
    // above the word index means the address lies past the array.
    assign mis  = |(req_addr & LO_MASK);
    assign oor  = |(req_addr >> (B + I));
    assign err  = mis | oor;
    assign widx = req_addr[B+I-1:B];

    assign accept = req_valid & ready_q;
    assign mem_we = accept &  req_we & ~err;
    assign mem_rd = accept & ~req_we & ~err;
    assign clr_we = (state_q == S_CLEAR) & rst_n;

    // ---------------------------------------------------------------
    // Control FSM: clear sweep, then accept requests forever
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    cnt_q   <= cnt_q + 1'b1;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign req_ready = ready_q;

    // ---------------------------------------------------------------
    // Storage: contents survive reset; only the clear sweep zeroes it.
    // Requests are never accepted while clearing, so the two write
    // sources cannot collide.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (req_be[i]) begin
                    mem_q[widx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_rd) begin
            rdata_q <= mem_q[widx];
        end
    end

    // ---------------------------------------------------------------
    // Response stage 1: flags reset, data gated so that idle cycles,
    // writes and errors all present zero.
    // ---------------------------------------------------------------
    always_comb begin
        v1_d = accept;
        e1_d = accept & err;
        r1_d = mem_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            r1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            e1_q <= e1_d;
            r1_q <= r1_d;
        end
    end

    assign s1_data = r1_q ? rdata_q : '0;

    // ---------------------------------------------------------------
    // Optional output register for the two-cycle variant
    // ---------------------------------------------------------------
    if (OUT_REG) begin : g_oreg
        logic              v2_q;
        logic              e2_q;
        logic [DATA_W-1:0] d2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                d2_q <= s1_data;
            end
        end

        assign rsp_valid = v2_q;
        assign rsp_err   = e2_q;
        assign rsp_rdata = d2_q;
    end else begin : g_direct
        assign rsp_valid = v1_q;
        assign rsp_err   = e1_q;
        assign rsp_rdata = s1_data;
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized and directed checks of data_ram against an
// array/queue model; a second small 64-bit instance covers OUT_REG=1.
module tb_data_ram;

    localparam int DEPTH = 256;
    localparam int OREG  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    logic        rst2_n;
    logic        d2_valid;
    logic        d2_we;
    logic [31:0] d2_addr;
    logic [63:0] d2_wdata;
    logic [7:0]  d2_be;
    logic        d2_ready;
    logic        d2_rvalid;
    logic [63:0] d2_rdata;
    logic        d2_err;
    logic        d2_busy;

    data_ram dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    data_ram #(
        .DATA_W         (64),
        .DEPTH          (16),
        .ADDR_W         (32),
        .OUT_REG        (1'b1),
        .CLEAR_ON_RESET (1'b0)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .req_valid (d2_valid),
        .req_ready (d2_ready),
        .req_we    (d2_we),
        .req_addr  (d2_addr),
        .req_wdata (d2_wdata),
        .req_be    (d2_be),
        .rsp_valid (d2_rvalid),
        .rsp_rdata (d2_rdata),
        .rsp_err   (d2_err),
        .busy      (d2_busy)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } obs_t;

    rsp_t        q[$];
    obs_t        log_q[$];
    logic [31:0] m [DEPTH];
    int          clr_left;
    bit          rdy_m;
    int          edge_n;
    int          total;
    int          bad;
    int          zero_cnt;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] lg(int k);
        if (k < log_q.size()) return {log_q[k].err, log_q[k].data};
        return 'x;
    endfunction

    // Model: one accepted request -> one queued response
    task automatic accept_req();
        rsp_t r;
        int   w;
        r.due  = edge_n + OREG;
        r.err  = (req_addr % 4 != 0) || (req_addr >= DEPTH * 4);
        r.data = '0;
        if (!r.err) begin
            w = int'(req_addr / 4);
            if (req_we) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) m[w][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                r.data = m[w];
            end
        end
        q.push_back(r);
    endtask

    task automatic compare();
        logic        ev;
        logic        ee;
        logic [31:0] ed;
        rsp_t        r;
        ev = 1'b0;
        ee = 1'b0;
        ed = '0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            r  = q.pop_front();
            ev = 1'b1;
            ee = r.err;
            ed = r.data;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_err", 64'(rsp_err), 64'(ee));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(ed));
        chk("req_ready", 64'(req_ready), 64'(rdy_m));
        chk("busy", 64'(busy), 64'(clr_left > 0));
        if (rsp_valid) begin
            log_q.push_back('{rsp_err, rsp_rdata});
            if (!rsp_err && rsp_rdata == 32'h0) zero_cnt++;
        end
    endtask

    task automatic step();
        bit acc;
        @(posedge clk);
        edge_n++;
        if (rst_n) begin
            acc = req_valid && rdy_m;
            if (acc) accept_req();
            if (clr_left > 0) begin
                m[DEPTH - clr_left] = '0;
                clr_left--;
                if (clr_left == 0) rdy_m = 1'b1;
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset(int n);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        q.delete();
        clr_left  = DEPTH;
        rdy_m     = 1'b0;
        #1;
        compare();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic issue(bit we, logic [31:0] a, logic [31:0] d,
                         logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        step();
    endtask

    task automatic idle(int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic rand_req();
        int          r;
        int          w;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        w = $urandom_range(0, 31);
        a = 32'(w * 4);
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = a | (32'h1 << $urandom_range(10, 31));
        req_valid = ($urandom_range(0, 9) < 7);
        req_we    = 1'($urandom);
        req_addr  = a;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // Counts cycles with busy high right after release; requests are
    // offered throughout and must all be refused.
    task automatic clear_sweep(string nm);
        int n;
        n = 0;
        while (busy && n < 400) begin
            n++;
            rand_req();
            step();
            if (n == 1) chk("d2_ready_rel", 64'(d2_ready), 64'd1);
        end
        req_valid = 1'b0;
        chk(nm, 64'(n), 64'd256);
    endtask

    task automatic d2_set(bit v, bit we, logic [31:0] a, logic [63:0] d,
                          logic [7:0] be);
        d2_valid = v;
        d2_we    = we;
        d2_addr  = a;
        d2_wdata = d;
        d2_be    = be;
        step();
    endtask

    task automatic d2_chk(string nm, bit v, bit e, logic [63:0] d);
        chk({nm, "_v"}, 64'(d2_rvalid), 64'(v));
        chk({nm, "_e"}, 64'(d2_err), 64'(e));
        chk({nm, "_d"}, d2_rdata, d);
    endtask

    localparam logic [31:0] A = 32'hCAFEF00D;
    localparam logic [31:0] B = 32'h5A5A1234;

    initial begin
        total = 0; bad = 0; edge_n = 0; zero_cnt = 0;
        rst_n = 1'b0; rst2_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0;
        d2_valid = 1'b0; d2_we = 1'b0; d2_addr = '0;
        d2_wdata = '0; d2_be = '0;
        clr_left = DEPTH; rdy_m = 1'b0;

        @(negedge clk);
        do_reset(3);
        chk("d2_rst_ready", 64'(d2_ready), 64'd0);
        chk("d2_rst_busy", 64'(d2_busy), 64'd0);
        rst2_n = 1'b1;
        clear_sweep("busy_len1");

        zero_cnt = 0;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i * 4), '0, '0);
        idle(2);
        chk("zero_reads", 64'(zero_cnt), 64'd256);

        log_q.delete();
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b1, 32'h10, 32'h11223344, 4'h5);
        issue(1'b0, 32'h10, '0, 4'h0);
        chk("lat_rd_v", 64'(rsp_valid), 64'd1);
        chk("merge_rd", 64'(rsp_rdata), 64'h00000000DE22BE44);
        idle(1);
        chk("model_w4", 64'(m[4]), 64'h00000000DE22BE44);
        chk("merge_n", 64'(log_q.size()), 64'd3);

        log_q.delete();
        issue(1'b1, 32'h0, A, 4'hF);
        issue(1'b0, 32'h0, '0, 4'h0);
        issue(1'b1, 32'h4, B, 4'hF);
        issue(1'b0, 32'h4, '0, 4'h0);
        idle(1);
        chk("b2b_0", 64'(lg(0)), 64'(33'h0_00000000));
        chk("b2b_1", 64'(lg(1)), 64'({1'b0, A}));
        chk("b2b_2", 64'(lg(2)), 64'(33'h0_00000000));
        chk("b2b_3", 64'(lg(3)), 64'({1'b0, B}));

        log_q.delete();
        issue(1'b0, 32'h2, '0, 4'hF);
        issue(1'b0, 32'h400, '0, 4'hF);
        issue(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF);
        issue(1'b0, 32'h0, '0, 4'h0);
        idle(1);
        chk("err_mis", 64'(lg(0)), 64'(33'h1_00000000));
        chk("err_oor", 64'(lg(1)), 64'(33'h1_00000000));
        chk("err_wr", 64'(lg(2)), 64'(33'h1_00000000));
        chk("err_keep", 64'(lg(3)), 64'({1'b0, A}));

        // 64-bit, OUT_REG=1 instance: two-cycle responses
        d2_set(1'b1, 1'b1, 32'h78, 64'h0123456789ABCDEF, 8'hFF);
        d2_chk("d2_a0", 1'b0, 1'b0, 64'h0);
        d2_set(1'b1, 1'b1, 32'h78, 64'hAA55AA55AA55AA55, 8'h80);
        d2_chk("d2_a1", 1'b1, 1'b0, 64'h0);
        d2_set(1'b1, 1'b0, 32'h78, 64'h0, 8'h00);
        d2_chk("d2_a2", 1'b1, 1'b0, 64'h0);
        d2_set(1'b1, 1'b0, 32'h80, 64'h0, 8'hFF);
        d2_chk("d2_a3", 1'b1, 1'b0, 64'hAA23456789ABCDEF);
        d2_set(1'b1, 1'b0, 32'h7C, 64'h0, 8'hFF);
        d2_chk("d2_a4", 1'b1, 1'b1, 64'h0);
        d2_set(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        d2_chk("d2_a5", 1'b1, 1'b1, 64'h0);
        d2_set(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        d2_chk("d2_a6", 1'b0, 1'b0, 64'h0);

        // reset with a read still in the output pipeline
        d2_set(1'b1, 1'b0, 32'h78, 64'h0, 8'h00);
        d2_chk("d2_b0", 1'b0, 1'b0, 64'h0);
        rst2_n   = 1'b0;
        d2_valid = 1'b0;
        #1;
        d2_chk("d2_b1", 1'b0, 1'b0, 64'h0);
        chk("d2_b1_rdy", 64'(d2_ready), 64'd0);
        d2_set(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        d2_chk("d2_b2", 1'b0, 1'b0, 64'h0);
        rst2_n = 1'b1;
        d2_set(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
        d2_chk("d2_b3", 1'b0, 1'b0, 64'h0);
        chk("d2_b3_rdy", 64'(d2_ready), 64'd1);

        // randomized interleaved traffic
        for (int i = 0; i < 3000; i++) begin
            rand_req();
            step();
        end
        idle(2);

        // reset mid-clear: sweep must restart from word 0
        do_reset(2);
        repeat (100) step();
        do_reset(2);
        clear_sweep("busy_len2");
        zero_cnt = 0;
        for (int i = 0; i < 32; i++) issue(1'b0, 32'(i * 4), '0, '0);
        idle(2);
        chk("zero_after_rst", 64'(zero_cnt), 64'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
